// File: rtl/adventure_pkg.sv
// ============================================================================
// adventure_pkg: shared widths, compositor FSM states and room-table packing.
// Rev 1.0
// ============================================================================
`default_nettype none

package adventure_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BLANK = 1'b1
  } comp_state_e;

  function automatic int idx_width(input int num_rooms);
    return (num_rooms <= 1) ? 1 : $clog2(num_rooms);
  endfunction

  function automatic int cnt_width(input int blank_frames);
    return (blank_frames < 1) ? 1 : $clog2(blank_frames + 1);
  endfunction

  // One table entry {x, y, idx}, right-aligned; callers truncate to the entry width.
  function automatic logic [31:0] room_entry(input int x, input int y, input int idx,
                                             input int coord_w, input int idx_w);
    int xm;
    int ym;
    int im;
    xm = x & ((1 << coord_w) - 1);
    ym = y & ((1 << coord_w) - 1);
    im = idx & ((1 << idx_w) - 1);
    return 32'((xm << (coord_w + idx_w)) | (ym << idx_w) | im);
  endfunction

endpackage

`default_nettype wire

// File: rtl/room_lookup.sv
// ============================================================================
// room_lookup: combinational coordinate-table search, lowest entry wins.
// Rev 1.0
// ============================================================================
`default_nettype none

module room_lookup
  import adventure_pkg::*;
#(
  parameter int NUM_ROOMS   = 12,
  parameter int COORD_W     = 4,
  parameter int NUM_ENTRIES = 12,
  parameter int IDX_W       = idx_width(NUM_ROOMS),
  parameter logic [NUM_ENTRIES*(2*COORD_W+IDX_W)-1:0] ROOM_TABLE = '0
) (
  input  logic [COORD_W-1:0] map_x_i,
  input  logic [COORD_W-1:0] map_y_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  localparam int ENTRY_W = 2 * COORD_W + IDX_W;
  localparam logic [IDX_W:0] ROOMS_LIM = (IDX_W + 1)'(NUM_ROOMS);

  logic [NUM_ENTRIES-1:0] w_hit;
  logic [IDX_W-1:0]       w_idx [NUM_ENTRIES];

  genvar k;
  for (k = 0; k < NUM_ENTRIES; k++) begin : g_entry
    localparam logic [ENTRY_W-1:0] ENTRY = ROOM_TABLE[k*ENTRY_W +: ENTRY_W];
    assign w_idx[k] = ENTRY[IDX_W-1:0];
    assign w_hit[k] = (ENTRY[ENTRY_W-1 -: COORD_W] == map_x_i) &&
                      (ENTRY[IDX_W+COORD_W-1 -: COORD_W] == map_y_i) &&
                      ({1'b0, ENTRY[IDX_W-1:0]} < ROOMS_LIM);
  end

  // Scan high to low so the lowest-numbered hit overrides; idx is 0 on a miss.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        valid_o = 1'b1;
        idx_o   = w_idx[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/room_compositor.sv
// ============================================================================
// room_compositor: frame-synchronous room selection with post-change blanking.
// Rev 1.0
// ============================================================================
`default_nettype none

module room_compositor
  import adventure_pkg::*;
#(
  parameter int NUM_ROOMS    = 12,
  parameter int COORD_W      = 4,
  parameter int PIX_W        = 8,
  parameter int NUM_ENTRIES  = 12,
  parameter logic [NUM_ENTRIES*(2*COORD_W+idx_width(NUM_ROOMS))-1:0] ROOM_TABLE = '0,
  parameter int BLANK_FRAMES = 2,
  parameter logic [PIX_W-1:0] BG_COLOR = 8'h00
) (
  input  logic                         clk_vga,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic [COORD_W-1:0]           mapX,
  input  logic [COORD_W-1:0]           mapY,
  input  logic [NUM_ROOMS*PIX_W-1:0]   room_pixels,
  output logic [PIX_W-1:0]             mapData,
  output logic [idx_width(NUM_ROOMS)-1:0] room_id,
  output logic                         room_valid,
  output logic                         busy
);

  localparam int IDX_W = idx_width(NUM_ROOMS);
  localparam int CNT_W = cnt_width(BLANK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  comp_state_e      state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [IDX_W-1:0] room_id_q, room_id_d;
  logic             room_valid_q, room_valid_d;
  logic             busy_q;
  logic [PIX_W-1:0] map_data_q;

  logic             w_lk_valid;
  logic [IDX_W-1:0] w_lk_idx;
  logic             w_change;
  logic [PIX_W-1:0] w_pix_sel;

  room_lookup #(
    .NUM_ROOMS  (NUM_ROOMS),
    .COORD_W    (COORD_W),
    .NUM_ENTRIES(NUM_ENTRIES),
    .IDX_W      (IDX_W),
    .ROOM_TABLE (ROOM_TABLE)
  ) u_lookup (
    .map_x_i(mapX),
    .map_y_i(mapY),
    .valid_o(w_lk_valid),
    .idx_o  (w_lk_idx)
  );

  assign w_change = frame_start &&
                    ({w_lk_valid, w_lk_idx} != {room_valid_q, room_id_q});

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    room_id_d    = room_id_q;
    room_valid_d = room_valid_q;
    if (w_change) begin
      room_id_d    = w_lk_idx;
      room_valid_d = w_lk_valid;
      if (BLANK_FRAMES > 0) begin
        state_d     = ST_BLANK;
        frame_cnt_d = CNT_LOAD;
      end
    end else if (frame_start && (state_q == ST_BLANK)) begin
      frame_cnt_d = frame_cnt_q - CNT_ONE;
      if (frame_cnt_q == CNT_ONE) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Select from the room being displayed after this edge, giving 1-cycle pixel latency.
  always_comb begin
    w_pix_sel = '0;
    for (int r = 0; r < NUM_ROOMS; r++) begin
      if (room_id_d == IDX_W'(r)) begin
        w_pix_sel = room_pixels[r*PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      room_id_q    <= '0;
      room_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      map_data_q   <= BG_COLOR;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      room_id_q    <= room_id_d;
      room_valid_q <= room_valid_d;
      busy_q       <= (state_d == ST_BLANK);
      map_data_q   <= ((state_d == ST_BLANK) || !room_valid_d) ? BG_COLOR : w_pix_sel;
    end
  end

  assign mapData    = map_data_q;
  assign room_id    = room_id_q;
  assign room_valid = room_valid_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_room_compositor.sv
// ============================================================================
// tb_room_compositor: directed stimulus, per-cycle reference model and literal checks.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_room_compositor;
  import adventure_pkg::*;

  localparam int NR = 12;
  localparam int CW = 4;
  localparam int PW = 8;
  localparam int NE = 12;
  localparam int IW = 4;
  localparam int EW = 2 * CW + IW;

  localparam int TX [NE] = '{3, 3, 1, 1, 4, 7,  7, 0, 0, 0, 0, 0};
  localparam int TY [NE] = '{5, 6, 2, 2, 6, 7,  7, 0, 0, 0, 0, 0};
  localparam int TI [NE] = '{0, 1, 0, 5, 2, 13, 3, 0, 0, 0, 0, 0};

  function automatic logic [NE*EW-1:0] build_table();
    logic [NE*EW-1:0] t;
    t = '0;
    for (int k = 0; k < NE; k++) begin
      t[k*EW +: EW] = EW'(room_entry(TX[k], TY[k], TI[k], CW, IW));
    end
    return t;
  endfunction

  localparam logic [NE*EW-1:0] TABLE = build_table();

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic [CW-1:0] mapX, mapY;
  logic [NR*PW-1:0] pix;

  logic [PW-1:0] md2, md0;
  logic [IW-1:0] id2, id0;
  logic          v2, v0, b2, b0;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  room_compositor #(
    .NUM_ROOMS(NR), .COORD_W(CW), .PIX_W(PW), .NUM_ENTRIES(NE),
    .ROOM_TABLE(TABLE), .BLANK_FRAMES(2), .BG_COLOR(8'h00)
  ) dut (
    .clk_vga(clk), .reset(reset), .frame_start(frame_start),
    .mapX(mapX), .mapY(mapY), .room_pixels(pix),
    .mapData(md2), .room_id(id2), .room_valid(v2), .busy(b2)
  );

  room_compositor #(
    .NUM_ROOMS(NR), .COORD_W(CW), .PIX_W(PW), .NUM_ENTRIES(NE),
    .ROOM_TABLE(TABLE), .BLANK_FRAMES(0), .BG_COLOR(8'h3C)
  ) dut0 (
    .clk_vga(clk), .reset(reset), .frame_start(frame_start),
    .mapX(mapX), .mapY(mapY), .room_pixels(pix),
    .mapData(md0), .room_id(id0), .room_valid(v0), .busy(b0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 models BLANK_FRAMES=2, index 1 models BLANK_FRAMES=0.
  localparam int BF  [2] = '{2, 0};
  localparam int BGV [2] = '{8'h00, 8'h3C};
  int m_valid [2];
  int m_id    [2];
  int m_left  [2];
  int m_md    [2];

  function automatic void model_lookup(input int x, input int y, output int v, output int i);
    v = 0;
    i = 0;
    for (int k = 0; k < NE; k++) begin
      if (TX[k] == x && TY[k] == y && TI[k] < NR) begin
        v = 1;
        i = TI[k];
        return;
      end
    end
  endfunction

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_id[m] = 0; m_left[m] = 0; m_md[m] = BGV[m];
    end
  end

  always @(posedge clk) begin
    int v, i;
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        m_valid[m] = 0; m_id[m] = 0; m_left[m] = 0;
      end else if (frame_start) begin
        model_lookup(int'(mapX), int'(mapY), v, i);
        if (v != m_valid[m] || i != m_id[m]) begin
          m_valid[m] = v; m_id[m] = i; m_left[m] = BF[m];
        end else if (m_left[m] > 0) begin
          m_left[m] = m_left[m] - 1;
        end
      end
      m_md[m] = (m_left[m] > 0 || m_valid[m] == 0) ? BGV[m] : int'(pix[m_id[m]*PW +: PW]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m2_mapData", 32'(md2), 32'(m_md[0]));
      check("m2_room_id", 32'(id2), 32'(m_id[0]));
      check("m2_valid",   32'(v2),  32'(m_valid[0]));
      check("m2_busy",    32'(b2),  32'(m_left[0] > 0));
      check("m0_mapData", 32'(md0), 32'(m_md[1]));
      check("m0_room_id", 32'(id0), 32'(m_id[1]));
      check("m0_valid",   32'(v0),  32'(m_valid[1]));
      check("m0_busy",    32'(b0),  32'(m_left[1] > 0));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic frame(input int x, input int y);
    mapX = CW'(x);
    mapY = CW'(y);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    mapX = '0;
    mapY = '0;
    for (int r = 0; r < NR; r++) pix[r*PW +: PW] = PW'(8'h10 + r);
    @(negedge clk);
    step(2);
    check("rst_mapData", 32'(md2), 32'h00);
    check("rst_valid",   32'(v2),  32'h0);
    check("rst_busy",    32'(b2),  32'h0);
    check("rst_room_id", 32'(id2), 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;
    step(2);

    frame(3, 6);
    check("chg_room_id", 32'(id2), 32'h1);
    check("chg_busy",    32'(b2),  32'h1);
    check("chg_mapData", 32'(md2), 32'h00);
    check("bf0_busy",    32'(b0),  32'h0);
    check("bf0_mapData", 32'(md0), 32'h11);
    step(3);
    check("blank_hold", 32'(md2), 32'h00);
    frame(3, 6);
    check("blank_f1_busy", 32'(b2), 32'h1);
    step(2);
    frame(3, 6);
    check("blank_end_busy", 32'(b2),  32'h0);
    check("blank_end_pix",  32'(md2), 32'h11);
    pix[1*PW +: PW] = 8'h77;
    step(1);
    check("pix_latency", 32'(md2), 32'h77);

    mapX = 4'd4;
    step(3);
    check("mid_room_id", 32'(id2), 32'h1);
    check("mid_mapData", 32'(md2), 32'h77);
    frame(4, 6);
    check("mid_new_room", 32'(id2), 32'h2);
    step(1);
    frame(4, 6);
    frame(3, 5);
    check("reload_room", 32'(id2), 32'h0);
    frame(3, 5);
    check("reload_busy", 32'(b2), 32'h1);
    frame(3, 5);
    check("reload_done", 32'(b2),  32'h0);
    check("reload_pix",  32'(md2), 32'h10);

    frame(9, 9);
    check("unmap_valid", 32'(v2),  32'h0);
    check("unmap_busy",  32'(b2),  32'h1);
    check("unmap_md",    32'(md2), 32'h00);
    check("unmap_md0",   32'(md0), 32'h3C);
    frame(9, 9);
    frame(9, 9);
    check("unmap_idle_md", 32'(md2), 32'h00);

    frame(1, 2);
    check("alias_room_id", 32'(id2), 32'h0);
    frame(1, 2);
    frame(1, 2);
    pix[0 +: PW] = 8'hA5;
    step(1);
    check("alias_A5",  32'(md2), 32'hA5);
    check("alias_A5_0", 32'(md0), 32'hA5);

    frame(7, 7);
    check("bad_idx_skip", 32'(id2), 32'h3);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_blank_busy", 32'(b2), 32'h0);
    check("rst_blank_id",   32'(id2), 32'h0);

    frame(7, 7);
    reset = 1'b1;
    frame(4, 6);
    reset = 1'b0;
    check("rst_fs_id",    32'(id2), 32'h0);
    check("rst_fs_valid", 32'(v2),  32'h0);
    check("rst_fs_busy",  32'(b2),  32'h0);
    check("rst_fs_md",    32'(md2), 32'h00);

    frame(1, 2);
    check("post_rst_valid", 32'(v2), 32'h1);
    check("post_rst_busy",  32'(b2), 32'h1);
    step(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
